// File: rtl/xy_input_buffer.sv
// rtl/xy_input_buffer.sv - per-port show-ahead packet FIFO for the mesh XY switch
// Head packet is presented combinationally from storage; sticky flags record misuse.
module xy_input_buffer #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH_LOG = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      wr_en_i,
    output logic                      rdy_o,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      vld_o,
    input  logic                      rd_en_i,
    output logic [FIFO_DEPTH_LOG:0]   count_o,
    output logic                      ovf_o,
    output logic                      udf_o
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;

    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG:0]   count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic                      udf_q, udf_d;
    logic                      wr_acc;
    logic                      rd_acc;

    // Count never exceeds DEPTH, so its MSB alone marks the full state.
    assign rdy_o   = ~count_q[FIFO_DEPTH_LOG];
    assign vld_o   = (count_q != '0);
    assign wr_acc  = wr_en_i & rdy_o;
    assign rd_acc  = rd_en_i & vld_o;
    assign data_o  = vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en_i & ~rdy_o);
        udf_d    = udf_q | (rd_en_i & ~vld_o);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (FIFO_DEPTH_LOG+1)'(1);
            2'b01:   count_d = count_q - (FIFO_DEPTH_LOG+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately unreset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule
